// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, default IDs and FSM state types for the bus arbiter.
package axi_pkg;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'h0;
  localparam logic [2:0] PROT_NONE   = 3'h0;
  localparam logic [3:0] DEF_INST_ID = 4'd0;
  localparam logic [3:0] DEF_DATA_ID = 4'd1;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } axi_cmd_t;
endpackage

// File: rtl/axi_write_ctrl.sv
// Single-outstanding AXI3 write channel driver: AW, W beats counted down from len, then B.
module axi_write_ctrl import axi_pkg::*; #(
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        data_wreq,
  input  logic [31:0] data_waddr,
  input  logic [7:0]  data_wlen,
  input  logic [2:0]  data_wsize,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_wgnt,
  output logic        data_wbeat,
  output logic        data_bdone,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic        w_idle
);
  wr_state_e state_q, state_d;
  axi_cmd_t  cmd_q;
  logic [7:0] beat_cnt;
  logic       bdone_q;
  logic       w_hs;

  assign w_hs = (state_q == W_DATA) && wready;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state_q <= W_IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (data_wreq) state_d = W_AW;
      W_AW:    if (awready) state_d = W_DATA;
      W_DATA:  if (wready && beat_cnt == 8'd0) state_d = W_RESP;
      W_RESP:  if (bvalid) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // beat_cnt holds the number of beats still to go after the current one
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      cmd_q    <= '0;
      beat_cnt <= '0;
      bdone_q  <= 1'b0;
    end else begin
      bdone_q <= (state_q == W_RESP) && bvalid;
      if (state_q == W_IDLE && data_wreq) begin
        cmd_q    <= '{addr: data_waddr, len: data_wlen, size: data_wsize};
        beat_cnt <= data_wlen;
      end else if (w_hs && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end

  assign data_wgnt  = aresetn && (state_q == W_IDLE) && data_wreq;
  assign data_wbeat = w_hs;
  assign data_bdone = bdone_q;
  assign w_idle     = (state_q == W_IDLE);

  assign awid    = DATA_ID;
  assign awaddr  = cmd_q.addr;
  assign awlen   = cmd_q.len;
  assign awsize  = cmd_q.size;
  assign awburst = BURST_INCR;
  assign awlock  = LOCK_NORMAL;
  assign awcache = CACHE_NONE;
  assign awprot  = PROT_NONE;
  assign awvalid = (state_q == W_AW);

  assign wid    = DATA_ID;
  assign wdata  = data_wdata;
  assign wstrb  = data_wstrb;
  assign wvalid = (state_q == W_DATA);
  assign wlast  = (state_q == W_DATA) && (beat_cnt == 8'd0);
  assign bready = (state_q == W_RESP);
endmodule

// File: rtl/axi_bus_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one AXI3 master; reads
// are single-outstanding and data reads wait for any write in flight to finish.
module axi_bus_arbiter import axi_pkg::*; #(
  parameter logic [3:0] INST_ID = DEF_INST_ID,
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_rreq,
  input  logic [31:0] inst_raddr,
  input  logic [7:0]  inst_rlen,
  input  logic [2:0]  inst_rsize,
  output logic        inst_rgnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  input  logic        data_rreq,
  input  logic [31:0] data_raddr,
  input  logic [7:0]  data_rlen,
  input  logic [2:0]  data_rsize,
  output logic        data_rgnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  input  logic        data_wreq,
  input  logic [31:0] data_waddr,
  input  logic [7:0]  data_wlen,
  input  logic [2:0]  data_wsize,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_wgnt,
  output logic        data_wbeat,
  output logic        data_bdone,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  rd_state_e r_state, r_next;
  axi_cmd_t  ar_cmd;
  logic [3:0] arid_q;
  logic       rd_is_data;
  logic       w_idle, data_go, inst_go, r_beat;
  logic       unused_ok;

  // No error path: response codes and returned IDs are not inspected.
  assign unused_ok = ^{rid, rresp, bid, bresp};

  // A data write requested this cycle wins over a data read so the read sees it.
  assign data_go = data_rreq && w_idle && !data_wreq;
  assign inst_go = inst_rreq && !data_go;
  assign r_beat  = (r_state == R_DATA) && rvalid;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (data_go || inst_go) r_next = R_AR;
      R_AR:    if (arready) r_next = R_DATA;
      R_DATA:  if (rvalid && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ar_cmd     <= '0;
      arid_q     <= '0;
      rd_is_data <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (data_go) begin
        ar_cmd     <= '{addr: data_raddr, len: data_rlen, size: data_rsize};
        arid_q     <= DATA_ID;
        rd_is_data <= 1'b1;
      end else if (inst_go) begin
        ar_cmd     <= '{addr: inst_raddr, len: inst_rlen, size: inst_rsize};
        arid_q     <= INST_ID;
        rd_is_data <= 1'b0;
      end
    end

  assign data_rgnt = aresetn && (r_state == R_IDLE) && data_go;
  assign inst_rgnt = aresetn && (r_state == R_IDLE) && inst_go;

  assign arid    = arid_q;
  assign araddr  = ar_cmd.addr;
  assign arlen   = ar_cmd.len;
  assign arsize  = ar_cmd.size;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_DATA);

  assign inst_rvalid = r_beat && !rd_is_data;
  assign data_rvalid = r_beat && rd_is_data;
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign inst_rlast  = inst_rvalid && rlast;
  assign data_rlast  = data_rvalid && rlast;

  axi_write_ctrl #(.DATA_ID(DATA_ID)) u_wr (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .data_wreq  (data_wreq),
    .data_waddr (data_waddr),
    .data_wlen  (data_wlen),
    .data_wsize (data_wsize),
    .data_wdata (data_wdata),
    .data_wstrb (data_wstrb),
    .data_wgnt  (data_wgnt),
    .data_wbeat (data_wbeat),
    .data_bdone (data_bdone),
    .awid       (awid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awlock     (awlock),
    .awcache    (awcache),
    .awprot     (awprot),
    .awvalid    (awvalid),
    .awready    (awready),
    .wid        (wid),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bvalid     (bvalid),
    .bready     (bready),
    .w_idle     (w_idle)
  );
endmodule

// File: doc/axi_bus_arbiter.md
AXI_BUS_ARBITER -- requirements
Module: axi_bus_arbiter

Interface
REQ-001 SHALL have parameter INST_ID, default 4'd0, the AXI ID for instruction-fetch reads.
REQ-002 SHALL have parameter DATA_ID, default 4'd1, the AXI ID for data reads and writes.
REQ-003 aclk  in  1  sole clock; all logic is rising-edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 inst_rreq/inst_raddr/inst_rlen/inst_rsize  in  1/32/8/3  fetch read request; held until inst_rgnt.
REQ-006 inst_rgnt/inst_rvalid/inst_rdata/inst_rlast  out  1/1/32/1  request accepted; returned read beat.
REQ-007 data_rreq/data_raddr/data_rlen/data_rsize  in  1/32/8/3  data read request; held until data_rgnt.
REQ-008 data_rgnt/data_rvalid/data_rdata/data_rlast  out  1/1/32/1  request accepted; returned read beat.
REQ-009 data_wreq/data_waddr/data_wlen/data_wsize  in  1/32/8/3  write request; held until data_wgnt.
REQ-010 data_wdata/data_wstrb  in  32/4  current write beat.
REQ-011 data_wgnt/data_wbeat/data_bdone  out  1/1/1  AW accepted; W beat accepted; B received.
REQ-012 ar{id,addr,len,size,burst,lock,cache,prot,valid}  out  4/32/8/3/2/2/4/3/1  AXI3 read address; arready in 1.
REQ-013 r{id,data,resp,last,valid}  in  4/32/2/1/1  AXI3 read data; rready out 1.
REQ-014 aw{id,addr,len,size,burst,lock,cache,prot,valid}  out  4/32/8/3/2/2/4/3/1  AXI3 write address; awready in 1.
REQ-015 w{id,data,strb,last,valid}  out  4/32/4/1/1  AXI3 write data; wready in 1.
REQ-016 b{id,resp,valid}  in  4/2/1  write response; bready out 1.

Function
REQ-017 Read FSM SHALL have states R_IDLE, R_AR, R_DATA; at most one read outstanding.
REQ-018 In R_IDLE, if data_rreq is high and the write FSM is in W_IDLE, SHALL latch the data request with arid=DATA_ID and go to R_AR; else if inst_rreq is high, SHALL latch the inst request with arid=INST_ID and go to R_AR.
REQ-019 Data reads SHALL stall while the write FSM is not in W_IDLE (read-after-write ordering); inst reads SHALL NOT stall on writes.
REQ-020 The {inst,data}_rgnt pulse SHALL be one cycle, on the R_IDLE->R_AR transition.
REQ-021 arvalid SHALL be registered, high exactly in R_AR; the AR handshake (arvalid&arready) SHALL move to R_DATA.
REQ-022 rready SHALL be high in R_DATA only; each beat SHALL pass combinationally to the latched requester (rvalid, rdata, rlast); the other requester's rvalid SHALL stay 0.
REQ-023 The beat with rlast SHALL return the FSM to R_IDLE; a new AR SHALL issue no earlier than the following cycle.
REQ-024 Write FSM SHALL have states W_IDLE, W_AW, W_DATA, W_RESP.
REQ-025 W_IDLE with data_wreq SHALL latch addr/len/size, pulse data_wgnt, load the beat counter with wlen, and go to W_AW.
REQ-026 awvalid SHALL be high exactly in W_AW; the handshake SHALL move to W_DATA.
REQ-027 In W_DATA, wvalid=1 and wdata/wstrb SHALL come from data_wdata/data_wstrb; each wvalid&wready SHALL pulse data_wbeat and decrement the counter.
REQ-028 wlast SHALL be high when the counter is 0; that beat's handshake SHALL move to W_RESP.
REQ-029 In W_RESP, bready=1; bvalid SHALL pulse data_bdone and return to W_IDLE.
REQ-030 Fixed outputs: arburst=awburst=2'b01 (INCR); lock/cache/prot=0; awid=wid=DATA_ID.
REQ-031 A simultaneous data_rreq and data_wreq in idle SHALL start the write first; the read SHALL follow after data_bdone.
REQ-032 Non-OKAY rresp/bresp SHALL be ignored (no error path).

Reset
REQ-033 On aresetn low, both FSMs SHALL enter idle asynchronously; all valid, ready, grant, pulse outputs, and counters SHALL be 0.
REQ-034 A reset mid-burst SHALL abandon the transaction; no beat SHALL be forwarded after release until a new grant.

Structure
REQ-035 Package axi_pkg SHALL hold the burst/lock/cache/prot encodings, the default IDs, and the read/write state enums.
REQ-036 The write path SHALL be sub-module axi_write_ctrl; read arbitration and routing stay in the top.

Verification
REQ-037 inst_rreq, raddr=0xBFC00000, len=3, arready=1 -> arid=0, arlen=3, four inst_rvalid beats, rlast on beat 4, FSM idle the next cycle.
REQ-038 inst_rreq and data_rreq in the same cycle -> data_rgnt first (arid=1); inst_rgnt the cycle after data rlast.
REQ-039 data_wreq len=0 at 0x1FAF0000, wstrb=4'hF, wready delayed 3 cycles -> wlast on the single beat, data_bdone one cycle after bvalid.
REQ-040 data_wreq and data_rreq together -> AW issued; AR for data not issued until after data_bdone; an inst read in between is granted.
REQ-041 aresetn low during beat 2 of a 4-beat read -> rready=0, arvalid=0, and no rvalid to requesters until the next grant.
